// File: rtl/fetch_queue_pkg.sv
// Shared pipeline types: the fetch-to-dispatch packet and the queue sizing macros.
`ifndef FETCH_QUEUE_PKG_SV
`define FETCH_QUEUE_PKG_SV

`define N_WAY    3
`define FQ_DEPTH 8

package fetch_queue_pkg;

  localparam int N_WAY    = `N_WAY;
  localparam int FQ_DEPTH = `FQ_DEPTH;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } FETCH_DISPATCH_PACKET;

endpackage

`endif

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and the dispatch decoders.
// First-word fall-through outputs; flush and reset empty the queue.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = `FQ_DEPTH,
  parameter int WAYS  = `N_WAY
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  FETCH_DISPATCH_PACKET [WAYS-1:0]    fetch_packet_in,
  input  logic [$clog2(WAYS+1)-1:0]          dispatch_num,
  output logic                               fq_ready,
  output FETCH_DISPATCH_PACKET [WAYS-1:0]    fetch_packet_out,
  output logic [$clog2(DEPTH+1)-1:0]         fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  FETCH_DISPATCH_PACKET entries [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;
  logic [CW-1:0]        lead;
  logic                 run;
  logic [CW-1:0]        enq_num;
  logic [CW-1:0]        deq_num;

  // DEPTH is a power of two, so modulo is plain truncation to PW bits.
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] ptr,
                                             input logic [PW-1:0] off);
    return ptr + off;
  endfunction

  // Only the leading run of valid lanes counts; anything after a gap is ignored.
  always_comb begin
    lead = '0;
    run  = 1'b1;
    for (int i = 0; i < WAYS; i++) begin
      if (run && fetch_packet_in[i].valid) lead = lead + CW'(1);
      else                                 run  = 1'b0;
    end
  end

  assign fq_ready = (CW'(DEPTH) - count) >= CW'(WAYS);
  assign enq_num  = fq_ready ? lead : '0;
  assign deq_num  = (CW'(dispatch_num) > count) ? count : CW'(dispatch_num);
  assign fq_count = count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (CW'(i) < enq_num) entries[wrap_idx(tail, PW'(i))] <= fetch_packet_in[i];
      end
      tail  <= wrap_idx(tail, PW'(enq_num));
      head  <= wrap_idx(head, PW'(deq_num));
      count <= count + enq_num - deq_num;
    end
  end

  // Lanes past the occupancy read as all-zero so the decoders see a noop.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      fetch_packet_out[i] = '0;
      if (CW'(i) < count) begin
        fetch_packet_out[i]       = entries[wrap_idx(head, PW'(i))];
        fetch_packet_out[i].valid = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int WAYS  = 3;

  logic                            clock;
  logic                            reset;
  logic                            flush;
  FETCH_DISPATCH_PACKET [WAYS-1:0] fetch_packet_in;
  logic [1:0]                      dispatch_num;
  logic                            fq_ready;
  FETCH_DISPATCH_PACKET [WAYS-1:0] fetch_packet_out;
  logic [3:0]                      fq_count;

  fetch_queue #(.DEPTH(DEPTH), .WAYS(WAYS)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .fetch_packet_in  (fetch_packet_in),
    .dispatch_num     (dispatch_num),
    .fq_ready         (fq_ready),
    .fetch_packet_out (fetch_packet_out),
    .fq_count         (fq_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  FETCH_DISPATCH_PACKET model_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] pc_ctr   = 32'h0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    FETCH_DISPATCH_PACKET exp_pkt;
    check({tag, " count"}, 128'(fq_count), 128'(model_q.size()));
    check({tag, " ready"}, 128'(fq_ready), 128'((DEPTH - model_q.size()) >= WAYS));
    for (int i = 0; i < WAYS; i++) begin
      exp_pkt = '0;
      if (i < model_q.size()) begin
        exp_pkt       = model_q[i];
        exp_pkt.valid = 1'b1;
      end
      check($sformatf("%s lane%0d", tag, i), 128'(fetch_packet_out[i]), 128'(exp_pkt));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at the falling edge.
  task automatic step(input string tag, input int mask, input int dn, input bit fl, input bit rs);
    int n_lead, n_enq, n_deq, occ;
    bit run;
    for (int i = 0; i < WAYS; i++) begin
      fetch_packet_in[i].valid = mask[i];
      fetch_packet_in[i].pc    = pc_ctr + 32'(4 * i);
      fetch_packet_in[i].npc   = pc_ctr + 32'(4 * i + 4);
      fetch_packet_in[i].inst  = $urandom;
    end
    dispatch_num = 2'(dn);
    flush        = fl;
    reset        = ~rs;
    n_lead = 0;
    run    = 1'b1;
    for (int i = 0; i < WAYS; i++) begin
      if (run && mask[i]) n_lead++;
      else                run = 1'b0;
    end
    occ   = model_q.size();
    n_enq = ((DEPTH - occ) >= WAYS) ? n_lead : 0;
    n_deq = (dn < occ) ? dn : occ;
    @(posedge clock);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      for (int i = 0; i < n_deq; i++) void'(model_q.pop_front());
      for (int i = 0; i < n_enq; i++) model_q.push_back(fetch_packet_in[i]);
      pc_ctr = pc_ctr + 32'(4 * n_enq);
    end
    @(negedge clock);
    check_outputs(tag);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; dispatch_num = '0; fetch_packet_in = '0;

    step("rst0", 7, 3, 0, 1);
    step("rst1", 7, 3, 0, 1);

    step("fill1", 7, 0, 0, 0);
    check("fill1 pc0", 128'(fetch_packet_out[0].pc), 128'(32'h00));
    check("fill1 pc2", 128'(fetch_packet_out[2].pc), 128'(32'h08));
    step("fill2", 7, 0, 0, 0);
    check("fill2 ready", 128'(fq_ready), 128'(1'b0));
    step("fill3_drop", 7, 0, 0, 0);
    check("drop count", 128'(fq_count), 128'(6));

    for (int k = 0; k < 11; k++) step($sformatf("steady%0d", k), 7, 3, 0, 0);

    step("flushA", 0, 0, 1, 0);
    step("two", 3, 0, 0, 0);
    check("two lane2 inv", 128'(fetch_packet_out[2].valid), 128'(1'b0));
    step("clip", 0, 3, 0, 0);
    check("clip count", 128'(fq_count), 128'(0));

    step("c3", 7, 0, 0, 0);
    step("c5", 3, 0, 0, 0);
    step("flush5", 7, 2, 1, 0);
    check("flush5 count", 128'(fq_count), 128'(0));
    step("post_flush", 1, 0, 0, 0);

    step("f0", 0, 0, 1, 0);
    step("f2", 3, 0, 0, 0);
    step("f5", 7, 0, 0, 0);
    step("f8", 7, 0, 0, 0);
    check("full count", 128'(fq_count), 128'(8));
    step("rst_flush", 7, 0, 1, 1);
    step("one", 1, 0, 0, 0);
    check("one lane1 inv", 128'(fetch_packet_out[1].valid), 128'(1'b0));

    // non-contiguous pattern: only lane 0 counts
    step("gap", 5, 0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      step("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer between the fetch stage and dispatch in the 3-way superscalar pipeline. It accepts up to three in-order `FETCH_DISPATCH_PACKET`s per cycle from fetch and presents the oldest up to three packets to the three dispatch-lane decoders. It decouples fetch from dispatch stalls and is cleared on a branch-mispredict flush.

## Interface
- `DEPTH`, default 8: number of packet entries. Must be a power of two and at least 2*`WAYS`.
- `WAYS`, default 3: superscalar width.
- `clock` input, 1 bit: the single clock.
- `reset` input, 1 bit: synchronous, active-low. The queue is cleared on a rising edge of `clock` while `reset`==0.
- `flush` input, 1 bit: mispredict squash. Empties the queue.
- `fetch_packet_in` input, `WAYS` x `FETCH_DISPATCH_PACKET`: packets from fetch, lane 0 oldest.
- `dispatch_num` input, $clog2(`WAYS`+1) bits: number of head packets dispatch consumes this cycle.
- `fq_ready` output, 1 bit: queue can accept a full `WAYS`-wide fetch group this cycle.
- `fetch_packet_out` output, `WAYS` x `FETCH_DISPATCH_PACKET`: the oldest packets, lane 0 = head. These feed the decoders.
- `fq_count` output, $clog2(`DEPTH`+1) bits: number of occupied entries.

## Operation
- Storage is a circular array of `DEPTH` packets with registered `head`, `tail` ($clog2(`DEPTH`) bits, wrap modulo `DEPTH`) and `count`.
- Enqueue:
  - Incoming valid lanes must be contiguous from lane 0.
  - `enq_num` = number of lanes with `.valid`==1, taken only when `fq_ready`==1, else 0.
  - Lanes 0..`enq_num`-1 are written to `tail`, `tail`+1, … with wrap.
  - Next `tail` = `tail` + `enq_num` (mod `DEPTH`).
  - A non-contiguous valid pattern is illegal input; only the leading contiguous valid lanes are counted.
- `fq_ready` = (`DEPTH` − `count`) ≥ `WAYS`, computed from registered `count` only. It does not depend on dispatch in the same cycle, so there is no combinational path from `dispatch_num` to `fq_ready`.
- Dequeue:
  - `deq_num` = min(`dispatch_num`, `count`). Excess requests are clipped, never underflow.
  - Next `head` = `head` + `deq_num` (mod `DEPTH`).
- Output, first-word fall-through:
  - Lane i = entry[(`head`+i) mod `DEPTH`], with `.valid` forced to (i < `count`).
  - Invalid lanes drive an all-zero packet. The decoders then default to noop.
- Count update: `count` ← `count` + `enq_num` − `deq_num`. Simultaneous enqueue and dequeue at any occupancy is legal, including full and empty.
- Flush: `head`, `tail` and `count` ← 0. Flush overrides enqueue and dequeue in the same cycle; packets presented during a flush cycle are discarded.
- Reset (`reset`==0): same as flush, and also clears all entries to zero. Reset dominates flush. Reset mid-stream discards all contents.

## Timing
- Reset values:
  - `count`=0, `head`=`tail`=0.
  - `fq_ready`=1.
  - `fq_count`=0.
  - All `fetch_packet_out` lanes all-zero with `.valid`=0.
- Enqueue-to-output latency is 1 cycle. A packet accepted at edge t appears on `fetch_packet_out` in the cycle after edge t, if it is within the first `WAYS` entries.
- Dequeue is immediate: lanes consumed at edge t are gone from the outputs after edge t.
- The queue never bypasses an input packet directly to the outputs in the same cycle it is fetched.
- `fq_ready` and `fq_count` are functions of registered state only.

## Structure
- `FETCH_DISPATCH_PACKET` is already in the shared package and is used unchanged.
- Add the following macros to the shared package:
  - `` `N_WAY `` (3).
  - `` `FQ_DEPTH `` (8), used as the default for `DEPTH` in the instantiation in the pipeline top.
- No sub-module: pointer arithmetic, count update and output selection are one flat module.
- The wrap-around index adder (pointer + offset mod `DEPTH`) may be a local function.

## Test plan
- Reset with `reset`=0 for 2 cycles, inputs valid → `fq_count`=0, `fq_ready`=1, all output `.valid`=0.
- Three 3-wide groups (PCs 0x00–0x20) enqueued, `dispatch_num`=0:
  - `fq_count` goes 3, 6, then `fq_ready`=0 at count 6 (DEPTH 8).
  - Lanes show PCs 0x00, 0x04, 0x08.
  - The third group is dropped.
- Steady state: 3 in, 3 out per cycle for 10 cycles → `fq_count` stays 3, PCs leave strictly in order, pointers wrap past entry 7 without corruption.
- `count`=2 and `dispatch_num`=3 → only 2 dequeued, `count`=0, no underflow. Lane 2 output `.valid`=0 before the edge.
- `count`=5, `flush`=1 with a valid group and `dispatch_num`=2 → next cycle `count`=0, outputs invalid. A subsequent group appears at lane 0.
- `flush`=1 and `reset`=0 simultaneously while full → full reset state. Then enqueue 1 packet → `fq_count`=1, lane 0 valid, lanes 1–2 invalid.
